sync_evt_collect: RTL and testbench
===================================

SYNC_EVT_COLLECT -- requirements
Module: sync_evt_collect

Interface
REQ-001 Parameter CNT_W, default 4, sets the width of the pending-event counter; legal range 2..8.
REQ-002 DST_CLK  input  1  destination-domain clock; all flops are posedge DST_CLK.
REQ-003 DST_CLRN  input  1  reset, asynchronous assert, active-low.
REQ-004 SYNC_Q  input  1  toggle level from the upstream 3-flop strict synchronizer (its DST_Q); each level change is one event.
REQ-005 EN  input  1  collection enable; 0 = hold.
REQ-006 EVT_RDY  input  1  consumer ready for one event.
REQ-007 CLR_OVF  input  1  single-cycle clear of the sticky overflow flag.
REQ-008 EVT_VLD  output  1  at least one pending event offered to the consumer.
REQ-009 EVT_CNT  output  CNT_W  pending-event count, registered.
REQ-010 EDGE_PULSE  output  1  registered one-cycle pulse per detected toggle.
REQ-011 OVF  output  1  sticky flag, set when an event is lost to saturation.

Function
REQ-012 States: INIT, RUN, HOLD; a 2-bit state register.
REQ-013 INIT lasts exactly one cycle after reset release: it loads SYNC_Q into the prev register, detects no edge, then moves to RUN if EN=1, otherwise to HOLD.
REQ-014 RUN moves to HOLD when EN=0; HOLD moves to RUN when EN=1; the transition takes effect on the next cycle.
REQ-015 The prev register samples SYNC_Q every cycle in all states.
REQ-016 edge = SYNC_Q XOR prev; it is valid only in RUN.
REQ-017 EDGE_PULSE is asserted for one cycle, in the cycle after SYNC_Q differs from prev (1-cycle latency).
REQ-018 In HOLD, edges are discarded, never counted, and produce no EDGE_PULSE.
REQ-019 EVT_VLD = (EVT_CNT != 0) AND state == RUN; no combinational path from SYNC_Q or EVT_RDY to EVT_VLD.
REQ-020 A pop is EVT_VLD AND EVT_RDY in the same cycle; each pop decrements EVT_CNT by 1 at the next edge.
REQ-021 An edge increments EVT_CNT by 1, in the same cycle EDGE_PULSE is asserted.
REQ-022 Edge and pop together: EVT_CNT is unchanged.
REQ-023 At EVT_CNT = 2^CNT_W-1, an edge without a pop leaves EVT_CNT unchanged and sets OVF.
REQ-024 Edge and pop together at saturation: EVT_CNT is unchanged and OVF is not set.
REQ-025 EVT_CNT never wraps: no decrement below 0, no increment above max.
REQ-026 OVF clears on CLR_OVF=1. If a new overflow occurs in the same cycle as CLR_OVF, set wins and OVF stays 1.
REQ-027 EVT_CNT is held in HOLD and resumes counting on return to RUN.

Reset
REQ-028 DST_CLRN low asynchronously forces: state=INIT, prev=0, EVT_CNT=0, EVT_VLD=0, EDGE_PULSE=0, OVF=0.
REQ-029 Reset asserted mid-operation discards all pending events, with no partial pop or count.
REQ-030 First functional edge detection is 2 cycles after DST_CLRN rises.

Structure
REQ-031 State encodings (INIT=0, RUN=1, HOLD=2) and the CNT_W default live in the shared sync package.
REQ-032 One sub-module, sync_evt_edge: the prev flop, the XOR and the EDGE_PULSE register; the counter and FSM are in the top.
REQ-033 No latches; all flops use asynchronous clear on DST_CLRN.

Verification
REQ-034 Reset release with SYNC_Q=1 and EN=1 -> INIT captures 1; no EDGE_PULSE; EVT_CNT=0 and EVT_VLD=0 for all cycles.
REQ-035 Toggle SYNC_Q 3 times, 2 cycles apart, EVT_RDY=0 -> 3 EDGE_PULSEs each 1 cycle after its toggle; EVT_CNT=3; EVT_VLD=1.
REQ-036 CNT_W=4, 16 toggles, EVT_RDY=0 -> EVT_CNT=15; OVF=1 after the 16th; CLR_OVF pulse -> OVF=0.
REQ-037 EVT_CNT=15, EVT_RDY=1, toggle in the same cycle -> EVT_CNT=15 and OVF stays 0.
REQ-038 EVT_CNT=2, EN=0, 2 toggles -> no EDGE_PULSE, EVT_VLD=0, EVT_CNT=2; then EN=1 and EVT_RDY=1 -> 2 pops, EVT_CNT=0.
REQ-039 EVT_CNT=5, DST_CLRN low mid-pop -> all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/sync_evt_collect_pkg.sv
// Shared definitions for the synchronized-event collector: FSM encodings and
// the default pending-counter width.
package sync_evt_collect_pkg;

    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/sync_evt_collect_edge.sv
// Toggle-to-event edge detector: remembers the previous synchronized level,
// flags a level change, and registers a one-cycle pulse per accepted change.
module sync_evt_edge (
    input  logic dst_clk_i,
    input  logic dst_clrn_i,
    input  logic sync_q_i,
    input  logic edge_en_i,
    output logic edge_o,
    output logic edge_pulse_o
);

    logic prev_q;
    logic pulse_q;

    // Edges outside RUN are swallowed here so nothing downstream sees them.
    assign edge_o = (sync_q_i ^ prev_q) & edge_en_i;

    // prev tracks the input every cycle so a held-off toggle is absorbed, not replayed later.
    always_ff @(posedge dst_clk_i or negedge dst_clrn_i) begin
        if (!dst_clrn_i) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= sync_q_i;
            pulse_q <= edge_o;
        end
    end

    assign edge_pulse_o = pulse_q;

endmodule

// File: rtl/sync_evt_collect.sv
// Destination-side event collector: counts toggles of a synchronized level as
// events, offers them to a consumer one at a time, and flags saturation loss.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   INIT  | one cycle after reset; prev loads SYNC_Q, no edge detected
//   RUN   | edges counted, pending events offered on EVT_VLD
//   HOLD  | edges discarded, count frozen, nothing offered
module sync_evt_collect
    import sync_evt_collect_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             DST_CLK,
    input  logic             DST_CLRN,
    input  logic             SYNC_Q,
    input  logic             EN,
    input  logic             EVT_RDY,
    input  logic             CLR_OVF,
    output logic             EVT_VLD,
    output logic [CNT_W-1:0] EVT_CNT,
    output logic             EDGE_PULSE,
    output logic             OVF
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             run;
    logic             edge_det;
    logic             pop;
    logic             ovf_set;

    sync_evt_edge u_edge (
        .dst_clk_i    (DST_CLK),
        .dst_clrn_i   (DST_CLRN),
        .sync_q_i     (SYNC_Q),
        .edge_en_i    (run),
        .edge_o       (edge_det),
        .edge_pulse_o (EDGE_PULSE)
    );

    // State register.
    always_ff @(posedge DST_CLK or negedge DST_CLRN) begin
        if (!DST_CLRN) state_q <= ST_INIT;
        else           state_q <= state_d;
    end

    // Next-state: INIT always leaves after one cycle; RUN/HOLD follow EN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = EN ? ST_RUN : ST_HOLD;
            ST_RUN:  if (!EN) state_d = ST_HOLD;
            ST_HOLD: if (EN)  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Outputs decoded from registered state and count only.
    always_comb begin
        run     = (state_q == ST_RUN);
        EVT_VLD = run && (cnt_q != CNT_ZERO);
    end

    // Saturating counter; a simultaneous edge and pop cancel, even at full.
    always_comb begin
        pop     = EVT_VLD & EVT_RDY;
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        if (edge_det && !pop) begin
            if (cnt_q == CNT_MAX) ovf_set = 1'b1;
            else                  cnt_d   = cnt_q + 1'b1;
        end else if (pop && !edge_det) begin
            cnt_d = cnt_q - 1'b1;
        end
        ovf_d = ovf_set | (ovf_q & ~CLR_OVF);
    end

    // Count and sticky overflow registers.
    always_ff @(posedge DST_CLK or negedge DST_CLRN) begin
        if (!DST_CLRN) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign EVT_CNT = cnt_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_sync_evt_collect.sv
module tb_sync_evt_collect;

    localparam int CNT_W = 4;

    logic             DST_CLK = 1'b0;
    logic             DST_CLRN;
    logic             SYNC_Q;
    logic             EN;
    logic             EVT_RDY;
    logic             CLR_OVF;
    logic             EVT_VLD;
    logic [CNT_W-1:0] EVT_CNT;
    logic             EDGE_PULSE;
    logic             OVF;

    sync_evt_collect #(.CNT_W(CNT_W)) dut (
        .DST_CLK    (DST_CLK),
        .DST_CLRN   (DST_CLRN),
        .SYNC_Q     (SYNC_Q),
        .EN         (EN),
        .EVT_RDY    (EVT_RDY),
        .CLR_OVF    (CLR_OVF),
        .EVT_VLD    (EVT_VLD),
        .EVT_CNT    (EVT_CNT),
        .EDGE_PULSE (EDGE_PULSE),
        .OVF        (OVF)
    );

    always #5 DST_CLK = ~DST_CLK;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge DST_CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge DST_CLK);
            #1;
        end
    endtask

    // Toggle while counting is expected: record the cycle the pulse must
    // appear and the count that must accompany it.
    task automatic toggle(input int exp_cnt);
        exp_t e;
        SYNC_Q  = ~SYNC_Q;
        e.cyc   = cyc + 1;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic toggle_silent();
        SYNC_Q = ~SYNC_Q;
    endtask

    // Scoreboard: every pulse must match the oldest expected entry.
    always @(negedge DST_CLK) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            check("pulse_missing", cyc, mon_e.cyc);
        end
        if (DST_CLRN === 1'b1 && EDGE_PULSE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pulse_unexpected", {31'd0, EDGE_PULSE}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_cycle", cyc, mon_e.cyc);
                check("pulse_cnt", {28'd0, EVT_CNT}, mon_e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        DST_CLRN = 1'b0;
        SYNC_Q   = 1'b1;
        EN       = 1'b1;
        EVT_RDY  = 1'b0;
        CLR_OVF  = 1'b0;
        step(2);
        check("rst_cnt", {28'd0, EVT_CNT}, 0);
        check("rst_vld", {31'd0, EVT_VLD}, 0);
        check("rst_pulse", {31'd0, EDGE_PULSE}, 0);
        check("rst_ovf", {31'd0, OVF}, 0);

        // Release with SYNC_Q=1: INIT absorbs the level, no event.
        DST_CLRN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("init_cnt", {28'd0, EVT_CNT}, 0);
            check("init_vld", {31'd0, EVT_VLD}, 0);
        end

        // Three toggles, two cycles apart, consumer not ready.
        toggle(1); step(2);
        toggle(2); step(2);
        toggle(3); step(2);
        check("three_cnt", {28'd0, EVT_CNT}, 3);
        check("three_vld", {31'd0, EVT_VLD}, 1);
        check("three_ovf", {31'd0, OVF}, 0);

        // Fill to saturation; the 16th toggle overflows.
        for (int i = 4; i <= 15; i++) begin
            toggle(i); step(1);
        end
        check("full_cnt", {28'd0, EVT_CNT}, 15);
        check("full_ovf", {31'd0, OVF}, 0);
        toggle(15); step(1);
        check("sat_cnt", {28'd0, EVT_CNT}, 15);
        check("sat_ovf", {31'd0, OVF}, 1);
        step(1);
        check("ovf_sticky", {31'd0, OVF}, 1);
        CLR_OVF = 1'b1; step(1); CLR_OVF = 1'b0;
        check("ovf_clr", {31'd0, OVF}, 0);

        // Edge and pop together at saturation: no change, no overflow.
        EVT_RDY = 1'b1; toggle(15); step(1); EVT_RDY = 1'b0;
        check("satpop_cnt", {28'd0, EVT_CNT}, 15);
        check("satpop_ovf", {31'd0, OVF}, 0);

        // New overflow in the same cycle as the clear: set wins.
        CLR_OVF = 1'b1; toggle(15); step(1); CLR_OVF = 1'b0;
        check("setwins_ovf", {31'd0, OVF}, 1);

        // Drain down to two pending events.
        EVT_RDY = 1'b1; step(13); EVT_RDY = 1'b0;
        check("drain_cnt", {28'd0, EVT_CNT}, 2);

        // HOLD: toggles are dropped, count frozen, nothing offered.
        EN = 1'b0; step(1);
        check("hold_vld", {31'd0, EVT_VLD}, 0);
        toggle_silent(); step(2);
        toggle_silent(); step(2);
        check("hold_cnt", {28'd0, EVT_CNT}, 2);
        check("hold_vld2", {31'd0, EVT_VLD}, 0);
        EN = 1'b1; EVT_RDY = 1'b1; step(1);
        check("resume_vld", {31'd0, EVT_VLD}, 1);
        check("resume_cnt", {28'd0, EVT_CNT}, 2);
        step(1);
        check("pop1_cnt", {28'd0, EVT_CNT}, 1);
        step(1);
        check("pop2_cnt", {28'd0, EVT_CNT}, 0);
        check("pop2_vld", {31'd0, EVT_VLD}, 0);
        step(2);
        check("nowrap_cnt", {28'd0, EVT_CNT}, 0);

        // Edge and pop together below saturation keep the count steady.
        toggle(1); step(1);
        toggle(1); step(1);
        toggle(1); step(1);
        check("edgepop_cnt", {28'd0, EVT_CNT}, 1);
        step(1);
        check("edgepop_drain", {28'd0, EVT_CNT}, 0);

        // Five pending, then reset in the middle of a pop cycle.
        EVT_RDY = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            toggle(i); step(1);
        end
        step(1);
        check("pre_rst_cnt", {28'd0, EVT_CNT}, 5);
        check("pre_rst_ovf", {31'd0, OVF}, 1);
        EVT_RDY = 1'b1;
        check("pre_rst_vld", {31'd0, EVT_VLD}, 1);
        #2;
        DST_CLRN = 1'b0;
        #1;
        check("async_cnt", {28'd0, EVT_CNT}, 0);
        check("async_vld", {31'd0, EVT_VLD}, 0);
        check("async_pulse", {31'd0, EDGE_PULSE}, 0);
        check("async_ovf", {31'd0, OVF}, 0);
        step(1);
        check("rst_hold_cnt", {28'd0, EVT_CNT}, 0);

        // After release, the first toggle following INIT is counted.
        EVT_RDY  = 1'b0;
        DST_CLRN = 1'b1;
        step(1);
        check("post_init_cnt", {28'd0, EVT_CNT}, 0);
        toggle(1); step(2);
        check("first_edge_cnt", {28'd0, EVT_CNT}, 1);
        check("first_edge_vld", {31'd0, EVT_VLD}, 1);

        step(2);
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
